// File: rtl/instr_dcd_burst.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instr_dcd_burst: SPI command decoder, multi-byte words, burst auto-increment |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module instr_dcd_burst #(
  parameter int ADDR_W     = 6,
  parameter int DATA_BYTES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    byte_sync,
  input  logic [7:0]              data_in,
  input  logic                    frame_end,
  output logic [7:0]              data_out,
  output logic                    read,
  output logic                    write,
  output logic [ADDR_W-1:0]       addr,
  input  logic [8*DATA_BYTES-1:0] data_read,
  output logic [8*DATA_BYTES-1:0] data_write,
  output logic                    busy
);

  localparam int DATA_W = 8 * DATA_BYTES;
  localparam int CNT_W  = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(DATA_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_FETCH = 2'd1,
    RD_DATA  = 2'd2,
    WR_DATA  = 2'd3
  } state_t;

  state_t            state;
  logic              burst;
  logic              fetch_wait;
  logic              addr_inc;
  logic [CNT_W-1:0]  byte_cnt;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] rd_shift;
  logic [DATA_W-1:0] wr_next;

  // Words travel MSB byte first, so both directions work by shifting left.
  assign rd_shift = rd_word << 8;
  assign wr_next  = (wr_word << 8) | DATA_W'(data_in);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      burst      <= 1'b0;
      fetch_wait <= 1'b0;
      addr_inc   <= 1'b0;
      byte_cnt   <= '0;
      rd_word    <= '0;
      wr_word    <= '0;
      data_out   <= 8'h00;
      read       <= 1'b0;
      write      <= 1'b0;
      addr       <= '0;
      data_write <= '0;
    end else begin
      read     <= 1'b0;
      write    <= 1'b0;
      addr_inc <= 1'b0;
      // A burst write advances the address one cycle after its strobe.
      if (addr_inc) begin
        addr <= addr + 1'b1;
      end

      if (frame_end) begin
        state      <= IDLE;
        byte_cnt   <= '0;
        data_out   <= 8'h00;
        fetch_wait <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (byte_sync) begin
              burst    <= data_in[6];
              addr     <= data_in[ADDR_W-1:0];
              byte_cnt <= '0;
              wr_word  <= '0;
              data_out <= 8'h00;
              if (data_in[7]) begin
                state <= WR_DATA;
              end else begin
                state      <= RD_FETCH;
                read       <= 1'b1;
                fetch_wait <= 1'b1;
              end
            end
          end

          RD_FETCH: begin
            if (fetch_wait) begin
              fetch_wait <= 1'b0;
            end else begin
              rd_word  <= data_read;
              data_out <= data_read[DATA_W-1 -: 8];
              state    <= RD_DATA;
            end
          end

          RD_DATA: begin
            if (byte_sync) begin
              if (byte_cnt != LAST_BYTE) begin
                byte_cnt <= byte_cnt + 1'b1;
                rd_word  <= rd_shift;
                data_out <= rd_shift[DATA_W-1 -: 8];
              end else begin
                byte_cnt <= '0;
                if (burst) begin
                  addr       <= addr + 1'b1;
                  state      <= RD_FETCH;
                  read       <= 1'b1;
                  fetch_wait <= 1'b1;
                end else begin
                  state    <= IDLE;
                  data_out <= 8'h00;
                end
              end
            end
          end

          WR_DATA: begin
            data_out <= 8'h00;
            if (byte_sync) begin
              if (byte_cnt != LAST_BYTE) begin
                byte_cnt <= byte_cnt + 1'b1;
                wr_word  <= wr_next;
              end else begin
                byte_cnt   <= '0;
                wr_word    <= '0;
                data_write <= wr_next;
                write      <= 1'b1;
                if (burst) begin
                  addr_inc <= 1'b1;
                end else begin
                  state <= IDLE;
                end
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_dcd_burst.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_instr_dcd_burst: bench for two decoder instances (1-byte and 2-byte words) |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_instr_dcd_burst;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic       rst_n [2];
  logic       bs    [2];
  logic       fe    [2];
  logic [7:0] din   [2];

  logic [7:0]  dout0, dout1;
  logic        rd0, rd1, wr0, wr1, busy0, busy1;
  logic [5:0]  addr0;
  logic [3:0]  addr1;
  logic [7:0]  dr0 = '0, dw0;
  logic [15:0] dr1 = '0, dw1;

  instr_dcd_burst #(.ADDR_W(6), .DATA_BYTES(1)) u_b1 (
    .clk(clk), .rst_n(rst_n[0]), .byte_sync(bs[0]), .data_in(din[0]), .frame_end(fe[0]),
    .data_out(dout0), .read(rd0), .write(wr0), .addr(addr0),
    .data_read(dr0), .data_write(dw0), .busy(busy0));

  instr_dcd_burst #(.ADDR_W(4), .DATA_BYTES(2)) u_b2 (
    .clk(clk), .rst_n(rst_n[1]), .byte_sync(bs[1]), .data_in(din[1]), .frame_end(fe[1]),
    .data_out(dout1), .read(rd1), .write(wr1), .addr(addr1),
    .data_read(dr1), .data_write(dw1), .busy(busy1));

  function automatic logic [7:0] pat0(int i);
    return 8'(i * 37 + 11);
  endfunction
  function automatic logic [15:0] pat1(int i);
    return (i == 3) ? 16'h1234 : 16'(i * 16'h3C5A + 16'h0B07);
  endfunction

  // Register files on the bus side: registered read data, write on strobe.
  logic [7:0]  rf0 [64];
  logic [15:0] rf1 [16];
  logic        rf_init = 1'b0;
  always @(posedge clk) begin
    if (!rf_init) begin
      for (int i = 0; i < 64; i++) rf0[i] <= pat0(i);
      for (int i = 0; i < 16; i++) rf1[i] <= pat1(i);
      rf_init <= 1'b1;
    end else begin
      if (rd0) dr0 <= rf0[addr0];
      if (wr0) rf0[addr0] <= dw0;
      if (rd1) dr1 <= rf1[addr1];
      if (wr1) rf1[addr1] <= dw1;
    end
  end

  typedef struct {int d; int w; int a; int v; int c;} ev_t;
  ev_t obs[$];
  ev_t expq[$];

  always @(negedge clk) begin
    if (rd0 || wr0) begin
      obs.push_back('{d:0, w:int'(wr0), a:int'(addr0), v:(wr0 ? int'(dw0) : 0), c:cyc});
      checks++;
      assert (!(rd0 && wr0)) else begin
        errors++;
        $error("FAIL strobe_excl dut=0 observed=read+write expected=one strobe");
      end
    end
    if (rd1 || wr1) begin
      obs.push_back('{d:1, w:int'(wr1), a:int'(addr1), v:(wr1 ? int'(dw1) : 0), c:cyc});
      checks++;
      assert (!(rd1 && wr1)) else begin
        errors++;
        $error("FAIL strobe_excl dut=1 observed=read+write expected=one strobe");
      end
    end
  end

  // Reference model state: register contents and last written word per instance.
  int mm [2][64];
  int lastw [2];
  logic [7:0] dq[$];

  function automatic logic [7:0]  g_dout(int d); return d ? dout1 : dout0; endfunction
  function automatic logic [31:0] g_addr(int d); return d ? 32'(addr1) : 32'(addr0); endfunction
  function automatic logic [31:0] g_dw(int d);   return d ? 32'(dw1) : 32'(dw0); endfunction
  function automatic logic        g_busy(int d); return d ? busy1 : busy0; endfunction
  function automatic logic        g_rd(int d);   return d ? rd1 : rd0; endfunction
  function automatic logic        g_wr(int d);   return d ? wr1 : wr0; endfunction

  task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs_v, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic [7:0] b, input bit with_fe, input int gap);
    din[d] = b; bs[d] = 1'b1; fe[d] = with_fe;
    tick();
    bs[d] = 1'b0; fe[d] = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic pulse_fe(input int d);
    fe[d] = 1'b1;
    tick();
    fe[d] = 1'b0;
    repeat (2) tick();
  endtask

  task automatic expect_ev(input int d, input int w, input int a, input int v, input int c);
    expq.push_back('{d:d, w:w, a:a, v:v, c:c});
  endtask

  task automatic check_events();
    ev_t e, o;
    while (expq.size() > 0) begin
      e = expq.pop_front();
      if (obs.size() == 0) begin
        chk("ev_missing", 32'(e.a), 32'hFFFF_FFFF);
      end else begin
        o = obs.pop_front();
        chk("ev_dut",   32'(o.d), 32'(e.d));
        chk("ev_kind",  32'(o.w), 32'(e.w));
        chk("ev_addr",  32'(o.a), 32'(e.a));
        chk("ev_wdata", 32'(o.v), 32'(e.v));
        chk("ev_cycle", 32'(o.c), 32'(e.c));
      end
    end
    chk("ev_extra", 32'(obs.size()), 32'd0);
    obs.delete();
  endtask

  task automatic check_reset_outputs(input int d);
    chk("rst_dout",  32'(g_dout(d)), 32'd0);
    chk("rst_read",  32'(g_rd(d)),   32'd0);
    chk("rst_write", 32'(g_wr(d)),   32'd0);
    chk("rst_addr",  g_addr(d),      32'd0);
    chk("rst_wdata", g_dw(d),        32'd0);
    chk("rst_busy",  32'(g_busy(d)), 32'd0);
  endtask

  // fe_mode: 0 = no frame_end, 1 = frame_end after the bytes,
  // 2 = last byte of dq arrives together with frame_end (and must be ignored).
  task automatic run_txn(input int d, input logic [7:0] cmd, input int nb, input int fe_mode);
    int db, mask, a, c, k, acc;
    logic [31:0] word;
    bit w, burst;
    db    = d ? 2 : 1;
    mask  = d ? 15 : 63;
    w     = cmd[7];
    burst = cmd[6];
    a     = int'(cmd[5:0]) & mask;
    acc   = 0;
    c     = cyc;
    if (!w) begin
      drive(d, cmd, 1'b0, 1);
      expect_ev(d, 0, a, 0, c + 1);
      chk("rd_lat_early", 32'(g_dout(d)), 32'd0);
      tick();
      chk("rd_lat", 32'(g_dout(d)), (32'(mm[d][a]) >> (8 * (db - 1))) & 32'hFF);
      repeat ($urandom_range(0, 3)) tick();
    end else begin
      drive(d, cmd, 1'b0, 2 + int'($urandom_range(0, 3)));
    end
    word = 32'(mm[d][a]);
    for (int i = 0; i < nb; i++) begin
      if (fe_mode == 2 && i == nb - 1) begin
        drive(d, dq[i], 1'b1, 3);
        break;
      end
      k = i % db;
      if (!w) chk("rd_byte", 32'(g_dout(d)), (word >> (8 * (db - 1 - k))) & 32'hFF);
      else    chk("wr_dout0", 32'(g_dout(d)), 32'd0);
      c = cyc;
      drive(d, dq[i], 1'b0, 2 + int'($urandom_range(0, 3)));
      if (w) begin
        acc = ((acc << 8) | int'(dq[i])) & ((db == 2) ? 32'hFFFF : 32'hFF);
        if (k == db - 1) begin
          expect_ev(d, 1, a, acc, c + 1);
          mm[d][a] = acc;
          lastw[d] = acc;
          acc = 0;
          if (burst) a = (a + 1) & mask;
        end
      end else if (k == db - 1 && burst) begin
        a = (a + 1) & mask;
        expect_ev(d, 0, a, 0, c + 1);
        word = 32'(mm[d][a]);
      end
    end
    if (fe_mode == 1) pulse_fe(d);
    chk("end_busy",  32'(g_busy(d)), 32'd0);
    chk("end_dout",  32'(g_dout(d)), 32'd0);
    chk("end_addr",  g_addr(d), 32'(a));
    chk("end_wdata", g_dw(d), 32'(lastw[d]));
    check_events();
  endtask

  initial begin
    int d, db, nb, fm, r;
    logic [7:0] cmd;
    for (int i = 0; i < 64; i++) mm[0][i] = int'(pat0(i));
    for (int i = 0; i < 16; i++) mm[1][i] = int'(pat1(i));
    lastw[0] = 0; lastw[1] = 0;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; bs[i] = 1'b0; fe[i] = 1'b0; din[i] = 8'h00;
    end
    repeat (3) tick();
    check_reset_outputs(0);
    check_reset_outputs(1);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    repeat (2) tick();

    // Single-byte write, then 2-byte read of a known word.
    dq = {8'hA5};
    run_txn(0, 8'h85, 1, 0);
    dq = {8'h00, 8'h00};
    run_txn(1, 8'h03, 2, 0);
    // Burst write wrapping 63 -> 0.
    dq = {8'h11, 8'h22};
    run_txn(0, 8'hFF, 2, 1);
    // Burst read from 0; third byte collides with frame_end.
    dq = {8'h00, 8'h00, 8'h00};
    run_txn(0, 8'h40, 3, 2);
    // Partial 2-byte write aborted, then a normal write decodes.
    dq = {8'hAB};
    run_txn(1, 8'h82, 1, 1);
    dq = {8'hCD, 8'hEF};
    run_txn(1, 8'h82, 2, 0);
    // Burst read wrapping 15 -> 0 on the 4-bit address instance.
    dq = {8'h00, 8'h00, 8'h00, 8'h00};
    run_txn(1, 8'h4F, 4, 1);

    // Reset between a write command and its data byte.
    for (int t = 0; t < 2; t++) begin
      drive(t, 8'h85, 1'b0, 1);
      rst_n[t] = 1'b0;
      #1;
      check_reset_outputs(t);
      tick();
      rst_n[t] = 1'b1;
      tick();
      lastw[t] = 0;
      dq.delete();
      run_txn(t, 8'hA5, 0, 1);
    end

    for (int t = 0; t < 60; t++) begin
      d   = t % 2;
      db  = d ? 2 : 1;
      cmd = 8'($urandom);
      if (cmd[6]) begin
        nb = int'($urandom_range(0, 3 * db + 1));
        fm = 1 + int'($urandom_range(0, 1));
        if (fm == 2 && nb == 0) nb = 1;
      end else begin
        r = int'($urandom_range(0, 2));
        if (r == 0)      begin nb = db; fm = 0; end
        else if (r == 1) begin nb = int'($urandom_range(0, db)); fm = 1; end
        else             begin nb = 1 + int'($urandom_range(0, db - 1)); fm = 2; end
      end
      dq.delete();
      for (int i = 0; i < nb; i++) dq.push_back(8'($urandom));
      run_txn(d, cmd, nb, fm);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
